// File: rtl/egress_port_reader.sv
// egress_port_reader: requests packets from one hydra egress port, checks the header against the
// payload and re-emits the words on a first/last framed valid/ready stream. Option: READER_TIMEOUT_EN.
module egress_port_reader #(
    parameter logic [3:0] PORT_ID    = 4'd0,
    parameter int         FIFO_DEPTH = 128,
    parameter int         REQ_FREE   = 65,
    parameter int         TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    input  logic        rd_sop,
    input  logic        rd_vld,
    input  logic [15:0] rd_data,
    input  logic        rd_eop,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [15:0] out_data,
    output logic        out_first,
    output logic        out_last,
    output logic [15:0] pkt_cnt,
    output logic        err_len,
    output logic        err_port,
    output logic        err_ovf,
`ifdef READER_TIMEOUT_EN
    output logic        err_tmo,
`endif
    input  logic        err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW+1:0] MAX_USED = (AW+2)'(FIFO_DEPTH - REQ_FREE);
`ifdef READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {IDLE, REQ, WAIT_SOP, HDR, DATA, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [17:0]   mem [FIFO_DEPTH];
    logic          hold_vld_q, hold_vld_d, hold_first_q, hold_first_d;
    logic [15:0]   hold_data_q, hold_data_d;
    logic [8:0]    len_q, len_d;
    logic [9:0]    word_cnt_q, word_cnt_d;
    logic          hdr_seen_q, hdr_seen_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic          err_len_q, err_len_d, err_port_q, err_port_d, err_ovf_q, err_ovf_d;
    logic          push, push_last, push_ok, pop, full, free_ok;
    logic          set_len, set_port, set_ovf;
    logic [17:0]   head;
`ifdef READER_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_tmo_q, err_tmo_d, set_tmo;
`endif

    // The holding-register word counts as occupied so DONE can re-request without waiting for its push.
    assign free_ok = ({1'b0, fifo_cnt_q} + {{(AW+1){1'b0}}, hold_vld_q}) <= MAX_USED;

    always_comb begin
        state_d      = state_q;
        hold_vld_d   = hold_vld_q;
        hold_first_d = hold_first_q;
        hold_data_d  = hold_data_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        hdr_seen_d   = hdr_seen_q;
        pkt_cnt_d    = pkt_cnt_q;
        ready        = 1'b0;
        push         = 1'b0;
        push_last    = 1'b0;
        set_len      = 1'b0;
        set_port     = 1'b0;
`ifdef READER_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        set_tmo      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (free_ok) state_d = REQ;
            end
            REQ: begin
                ready      = 1'b1;
                word_cnt_d = '0;
                hdr_seen_d = 1'b0;
                state_d    = WAIT_SOP;
`ifdef READER_TIMEOUT_EN
                tmo_cnt_d  = '0;
`endif
            end
            WAIT_SOP: begin
                if (rd_sop) begin
                    state_d = HDR;
                end
`ifdef READER_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    set_tmo = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            HDR: begin
                if (rd_eop) begin
                    state_d = DONE;
                end else if (rd_vld) begin
                    hold_vld_d   = 1'b1;
                    hold_first_d = 1'b1;
                    hold_data_d  = rd_data;
                    len_d        = rd_data[15:7];
                    hdr_seen_d   = 1'b1;
                    set_port     = rd_data[3:0] != PORT_ID;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (rd_eop) begin
                    state_d = DONE;
                end else if (rd_vld) begin
                    push         = 1'b1;
                    hold_first_d = 1'b0;
                    hold_data_d  = rd_data;
                    word_cnt_d   = word_cnt_q + 10'd1;
                end
            end
            DONE: begin
                push       = hold_vld_q;
                push_last  = 1'b1;
                hold_vld_d = 1'b0;
                pkt_cnt_d  = pkt_cnt_q + 16'd1;
                set_len    = !hdr_seen_q || (word_cnt_q != {1'b0, len_q});
                state_d    = free_ok ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        full     = fifo_cnt_q == DEPTH_C;
        out_vld  = fifo_cnt_q != '0;
        pop      = out_vld & out_rdy;
        push_ok  = push & ~full;
        set_ovf  = push & full;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push_ok, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        head      = mem[rd_ptr_q];
        out_data  = head[15:0];
        out_first = out_vld & head[17];
        out_last  = out_vld & head[16];
    end

    // A flag being set wins over err_clr in the same cycle.
    always_comb begin
        err_len_d  = (err_len_q  & ~err_clr) | set_len;
        err_port_d = (err_port_q & ~err_clr) | set_port;
        err_ovf_d  = (err_ovf_q  & ~err_clr) | set_ovf;
`ifdef READER_TIMEOUT_EN
        err_tmo_d  = (err_tmo_q  & ~err_clr) | set_tmo;
`endif
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= {hold_first_q, push_last, hold_data_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            hold_vld_q   <= 1'b0;
            hold_first_q <= 1'b0;
            hold_data_q  <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            hdr_seen_q   <= 1'b0;
            pkt_cnt_q    <= '0;
            err_len_q    <= 1'b0;
            err_port_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
`ifdef READER_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_tmo_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            hold_vld_q   <= hold_vld_d;
            hold_first_q <= hold_first_d;
            hold_data_q  <= hold_data_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            hdr_seen_q   <= hdr_seen_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_len_q    <= err_len_d;
            err_port_q   <= err_port_d;
            err_ovf_q    <= err_ovf_d;
`ifdef READER_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            err_tmo_q    <= err_tmo_d;
`endif
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign err_len  = err_len_q;
    assign err_port = err_port_q;
    assign err_ovf  = err_ovf_q;
`ifdef READER_TIMEOUT_EN
    assign err_tmo  = err_tmo_q;
`endif

endmodule
